ttl_decoder_scan_sequencer: RTL and testbench
=============================================

Name: ttl_decoder_scan_sequencer

Overview:
Upstream address/strobe sequencer for the 3-line to 8-line decoder: it drives the decoder's A bus and enable pins so the decoder scans its outputs one at a time. Used for display digit scanning and keyboard row strobing. Each address is held for a programmable dwell time, with a blanking gap between addresses so no two decoder outputs are ever active together. Supports one-shot sweep or continuous scan, up or down, from a loadable start address.

Parameters:
WIDTH_OUT, 8, number of decoder outputs scanned; A width is WIDTH_IN = $clog2(WIDTH_OUT), derived internally and never passed in
DWELL, 4, clock cycles the strobe is active per address (>= 1)
BLANK, 1, clock cycles the strobe is inactive between addresses (>= 1; zero not allowed)
DELAY_RISE, 0, output rise delay (time units)
DELAY_FALL, 0, output fall delay (time units)

Ports:
Clk  input  1  clock; all state changes on rising edge
Clear_bar  input  1  asynchronous active-low reset
Start  input  1  sampled in IDLE only; begins a sweep
Continuous  input  1  1 = wrap and keep scanning; 0 = stop after terminal address
Down  input  1  0 = count up, 1 = count down; sampled at each address advance
Load_bar  input  1  synchronous active-low load of D into A; IDLE only
D  input  WIDTH_IN  start address to load
A  output  WIDTH_IN  address to decoder A
Strobe  output  1  active-high enable, to decoder Enable3
Strobe_bar  output  1  always the complement of Strobe, to decoder Enable1_bar/Enable2_bar
Busy  output  1  high while in BLANK or ACTIVE
Done  output  1  one-cycle pulse when a one-shot sweep completes

Behaviour:
- Interface is fixed: one clock, Clk; reset is Clear_bar, asynchronous, active-low.
- Reset (Clear_bar=0, any time, including mid-sweep): state IDLE, A=0, Strobe=0, Strobe_bar=1, Busy=0, Done=0, internal counters 0. These hold while Clear_bar is low.
- All outputs are registered. Outputs use DELAY_RISE/DELAY_FALL.
- States: IDLE, BLANK, ACTIVE.
- IDLE:
  - Strobe=0, A held.
  - Load_bar=0: A <= D. A D value >= WIDTH_OUT loads WIDTH_OUT-1.
  - Start=1: go to BLANK and set Busy=1.
  - Load_bar=0 and Start=1 on the same edge: load and start both occur, and the sweep begins at the loaded D.
- BLANK: Strobe=0 for exactly BLANK cycles, then go to ACTIVE.
- ACTIVE: Strobe=1 for exactly DWELL cycles. On the last ACTIVE cycle's edge:
  - If A is the terminal address and Continuous=0: go to IDLE, Busy<=0, Done<=1 for one cycle. A holds the terminal address.
  - Otherwise: advance A and go to BLANK.
  - The Strobe fall and the A change occur on the same edge. Combined with BLANK >= 1, the decoder sees its enable off before and after every address change (break-before-make).
- Terminal address and wrap:
  - Up (Down=0): terminal is WIDTH_OUT-1; advance from it wraps to 0.
  - Down (Down=1): terminal is 0; advance from it wraps to WIDTH_OUT-1.
  - Non-power-of-2 WIDTH_OUT never emits an address >= WIDTH_OUT.
- Address period is BLANK+DWELL cycles. A full one-shot sweep from the start address s, counting up, lasts (WIDTH_OUT-s)*(BLANK+DWELL) cycles from the Start edge to the Done edge.
- Mode inputs changed mid-sweep:
  - Continuous cleared mid-sweep: scanning stops at the next terminal address.
  - Down changed mid-sweep: takes effect at the next advance, and the terminal address is judged with the new direction.
- Start, Load_bar and D are ignored while Busy=1.
- Counters: the dwell/blank counter is $clog2(max(DWELL,BLANK)+1) bits wide and never wraps; it resets to 0 on each state entry.

Test Plan:
- Reset mid-ACTIVE at A=3: drive Clear_bar=0 between edges -> immediately A=0, Strobe=0, Strobe_bar=1, Busy=0, Done=0. After release, remains in IDLE until Start.
- One-shot up (defaults), A=0, Start pulse -> per address: Strobe low 1 cycle, then high 4 cycles. A steps 0..7. Done pulses exactly 40 cycles after the Start edge; Busy falls on that edge; A stays at 7.
- Load_bar=0 with D=5, plus Start on the same edge, Down=1 -> addresses 5,4,3,2,1,0. Done after 30 cycles.
- Continuous=1 up from 6 -> A sequence 6,7,0,1 with a blank gap at each wrap. Clear Continuous while A=2 -> stops after A=7, Done pulses once.
- Break-before-make check with the decoder instance connected downstream -> at no sampled cycle is more than one Y bit high, and Y=8'b00000000 during every BLANK cycle.
- Start and Load_bar asserted while Busy, with D=2 -> no effect on the A sequence or timing.

Source files
------------

// File: rtl/ttl_decoder_scan_sequencer.sv
// Address/strobe sequencer for a 3-to-8 style decoder: scans addresses one at a time,
// holding each for DWELL cycles with a BLANK gap so no two decoder outputs ever overlap.
module ttl_decoder_scan_sequencer #(
    parameter int WIDTH_OUT  = 8,
    parameter int DWELL      = 4,
    parameter int BLANK      = 1,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0,
    localparam int WIDTH_IN  = $clog2(WIDTH_OUT)
) (
    input  logic                Clk,
    input  logic                Clear_bar,
    input  logic                Start,
    input  logic                Continuous,
    input  logic                Down,
    input  logic                Load_bar,
    input  logic [WIDTH_IN-1:0] D,
    output logic [WIDTH_IN-1:0] A,
    output logic                Strobe,
    output logic                Strobe_bar,
    output logic                Busy,
    output logic                Done,
    output logic [1:0]          state_dbg
);

    localparam int MAX_CNT = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0]       DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0]       BLANK_LAST = CW'(BLANK - 1);
    localparam logic [WIDTH_IN-1:0] LAST_ADDR  = WIDTH_IN'(WIDTH_OUT - 1);
    localparam logic [WIDTH_IN:0]   ADDR_LIMIT = (WIDTH_IN + 1)'(WIDTH_OUT);

    // Outputs are zero-delay in RTL; the delay parameters only describe the board-level part.
    if (DWELL < 1 || BLANK < 1 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_params
        $error("ttl_decoder_scan_sequencer: DWELL and BLANK must be >= 1, delays >= 0");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BLANK  = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    state_t              state_q, state_n;
    logic [WIDTH_IN-1:0] a_q, a_n;
    logic [CW-1:0]       cnt_q, cnt_n;
    logic                strobe_q, strobe_bar_q, busy_q, done_q;
    logic                done_n;
    logic [WIDTH_IN-1:0] load_addr, next_addr;
    logic                at_terminal;

    // Out-of-range loads clamp to the last decoder output so A never leaves 0..WIDTH_OUT-1.
    assign load_addr   = ({1'b0, D} >= ADDR_LIMIT) ? LAST_ADDR : D;
    assign at_terminal = Down ? (a_q == '0) : (a_q == LAST_ADDR);
    assign next_addr   = Down ? ((a_q == '0) ? LAST_ADDR : a_q - 1'b1)
                              : ((a_q == LAST_ADDR) ? '0 : a_q + 1'b1);

    always_comb begin
        state_n = state_q;
        a_n     = a_q;
        cnt_n   = cnt_q;
        done_n  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!Load_bar) a_n = load_addr;
                if (Start) begin
                    state_n = S_BLANK;
                    cnt_n   = '0;
                end
            end
            S_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_n = S_ACTIVE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            S_ACTIVE: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_n = '0;
                    if (at_terminal && !Continuous) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        // Address moves on the same edge the strobe drops.
                        a_n     = next_addr;
                        state_n = S_BLANK;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            cnt_q        <= '0;
            strobe_q     <= 1'b0;
            strobe_bar_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_n;
            a_q          <= a_n;
            cnt_q        <= cnt_n;
            strobe_q     <= (state_n == S_ACTIVE);
            strobe_bar_q <= (state_n != S_ACTIVE);
            busy_q       <= (state_n != S_IDLE);
            done_q       <= done_n;
        end
    end

    assign A          = a_q;
    assign Strobe     = strobe_q;
    assign Strobe_bar = strobe_bar_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_ttl_decoder_scan_sequencer.sv
// Directed bench for the decoder scan sequencer: expected addresses are queued per sweep
// and popped at each strobe rise; a behavioural 3-to-8 decoder sits downstream.
module tb_ttl_decoder_scan_sequencer;

    localparam int WO = 8;
    localparam int DW = 4;
    localparam int BL = 1;

    logic       Clk = 1'b0;
    logic       Clear_bar = 1'b0;
    logic       Start = 1'b0;
    logic       Continuous = 1'b0;
    logic       Down = 1'b0;
    logic       Load_bar = 1'b1;
    logic [2:0] D = 3'd0;
    logic [2:0] A;
    logic       Strobe, Strobe_bar, Busy, Done;
    logic [1:0] state_dbg;
    logic [7:0] y;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         s = 0;
    int         done_cnt;
    logic [2:0] exp_q[$];
    bit         mon_on = 1'b0;
    logic       prev_strobe;
    logic [2:0] prev_a;
    int         hi_len, lo_len;

    ttl_decoder_scan_sequencer #(
        .WIDTH_OUT(WO), .DWELL(DW), .BLANK(BL), .DELAY_RISE(0), .DELAY_FALL(0)
    ) dut (
        .Clk(Clk), .Clear_bar(Clear_bar), .Start(Start), .Continuous(Continuous),
        .Down(Down), .Load_bar(Load_bar), .D(D), .A(A), .Strobe(Strobe),
        .Strobe_bar(Strobe_bar), .Busy(Busy), .Done(Done), .state_dbg(state_dbg)
    );

    // Downstream decoder: Enable3 = Strobe, Enable1_bar/Enable2_bar = Strobe_bar.
    assign y = (Strobe === 1'b1 && Strobe_bar === 1'b0) ? (8'b1 << A) : 8'b0;

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic mon_reset();
        prev_strobe = Strobe;
        prev_a      = A;
        hi_len      = 0;
        lo_len      = 0;
    endtask

    task automatic tick();
        logic nb;
        @(posedge Clk);
        #1;
        cyc++;
        if (mon_on) begin
            nb = ~Strobe;
            chk("strobe_bar", Strobe_bar, nb);
            if (Busy && !Strobe) chk("blank_y", y, 0);
            if (Strobe && !prev_strobe) begin
                chk("blank_len", lo_len, BL);
                lo_len = 0;
                chk("stable_at_rise", A, prev_a);
                chk("addr_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("addr", A, exp_q.pop_front());
            end
            if (Strobe && prev_strobe) chk("stable_active", A, prev_a);
            if (!Strobe && prev_strobe) begin
                chk("dwell_len", hi_len, DW);
                hi_len = 0;
            end
            if (Strobe) hi_len++;
            else if (Busy) lo_len++;
            prev_strobe = Strobe;
            prev_a      = A;
        end
    endtask

    task automatic go();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        s = cyc;
        chk("busy_at_start", Busy, 1);
        chk("strobe_at_start", Strobe, 0);
    endtask

    task automatic load(input logic [2:0] v);
        Load_bar = 1'b0;
        D = v;
        tick();
        Load_bar = 1'b1;
        chk("load_a", A, v);
        chk("load_idle", Busy, 0);
    endtask

    task automatic push_range(input int from, input int to, input int stp);
        for (int i = from; i != to + stp; i += stp) exp_q.push_back(3'(i));
    endtask

    task automatic wait_addr(input logic [2:0] a, input int bound);
        for (int i = 0; i < bound; i++) begin
            tick();
            if (Strobe === 1'b1 && A === a) break;
        end
        chk("reach_addr", {Strobe, A}, {1'b1, a});
    endtask

    task automatic sweep_check(input int exp_len, input logic [2:0] exp_end);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (Done === 1'b1) break;
        end
        chk("done_seen", Done, 1);
        chk("sweep_len", cyc - s, exp_len);
        chk("busy_fall", Busy, 0);
        chk("a_hold", A, exp_end);
        chk("q_empty", exp_q.size(), 0);
        tick();
        chk("done_pulse", Done, 0);
    endtask

    initial begin
        // Reset values
        repeat (3) tick();
        chk("rst_a", A, 0);
        chk("rst_strobe", Strobe, 0);
        chk("rst_strobe_bar", Strobe_bar, 1);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        Clear_bar = 1'b1;
        mon_reset();
        mon_on = 1'b1;
        repeat (2) tick();

        // One-shot up from 0
        push_range(0, 7, 1);
        go();
        sweep_check(8 * (DW + BL), 3'd7);

        // Load D=5 and Start on the same edge, counting down
        Down = 1'b1;
        Load_bar = 1'b0;
        D = 3'd5;
        push_range(5, 0, -1);
        go();
        Load_bar = 1'b1;
        chk("load_start_a", A, 5);
        sweep_check(6 * (DW + BL), 3'd0);
        Down = 1'b0;

        // Continuous up from 6, cleared while A=2
        load(3'd6);
        chk("load_no_strobe", Strobe, 0);
        Continuous = 1'b1;
        push_range(6, 7, 1);
        push_range(0, 7, 1);
        go();
        wait_addr(3'd2, 100);
        Continuous = 1'b0;
        sweep_check(10 * (DW + BL), 3'd7);
        done_cnt = 0;
        repeat (10) begin
            tick();
            if (Done === 1'b1) done_cnt++;
        end
        chk("done_once", done_cnt, 0);

        // Direction flipped mid-sweep at A=2: 0,1,2,1,0 then stop at new terminal
        load(3'd0);
        exp_q = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd0};
        go();
        wait_addr(3'd2, 100);
        Down = 1'b1;
        sweep_check(5 * (DW + BL), 3'd0);
        Down = 1'b0;

        // Start/Load_bar/D=2 while busy are ignored
        push_range(0, 7, 1);
        go();
        repeat (6) tick();
        Start = 1'b1;
        Load_bar = 1'b0;
        D = 3'd2;
        repeat (12) tick();
        Start = 1'b0;
        Load_bar = 1'b1;
        sweep_check(8 * (DW + BL), 3'd7);

        // Asynchronous reset mid-ACTIVE at A=3
        load(3'd3);
        exp_q.push_back(3'd3);
        go();
        wait_addr(3'd3, 50);
        #2;
        Clear_bar = 1'b0;
        #1;
        chk("arst_a", A, 0);
        chk("arst_strobe", Strobe, 0);
        chk("arst_strobe_bar", Strobe_bar, 1);
        chk("arst_busy", Busy, 0);
        chk("arst_done", Done, 0);
        chk("arst_state", state_dbg, 0);
        mon_on = 1'b0;
        exp_q.delete();
        repeat (3) tick();
        chk("arst_hold_busy", Busy, 0);
        Clear_bar = 1'b1;
        mon_reset();
        mon_on = 1'b1;
        repeat (5) tick();
        chk("post_rst_busy", Busy, 0);
        chk("post_rst_strobe", Strobe, 0);
        chk("post_rst_a", A, 0);

        // Normal sweep still works after reset
        push_range(0, 7, 1);
        go();
        sweep_check(8 * (DW + BL), 3'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
